// File: rtl/led_pattern_driver_pkg.sv
// led_pkg: shared types and constants for the LED pattern driver
// Holds the display-mode and FSM-state enums, the mode-to-entry-state map
// and the 16-entry gamma table used when LED_GAMMA_EN is defined.
package led_pkg;
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_BOUNCE = 2'b11
    } led_mode_e;

    typedef enum logic [2:0] {
        S_OFF,
        S_STATIC,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_ROT,
        S_BOUNCE_L,
        S_BOUNCE_R
    } led_state_e;

    localparam logic [3:0] LED_GAMMA_LUT [16] = '{
        4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
    };

    function automatic led_state_e entry_state(input led_mode_e m);
        return m == MODE_STATIC ? S_STATIC :
               m == MODE_BLINK  ? S_BLINK_ON :
               m == MODE_ROTATE ? S_ROT : S_BOUNCE_L;
    endfunction
endpackage

// File: rtl/led_pattern_driver_if.sv
// led_pattern_driver_if: pattern load bus from the LED manager
// pattern_in    - LED byte to display
// pattern_valid - one-cycle load strobe for pattern_in and mode_in
// mode_in       - display mode applied with the pattern
interface led_pattern_driver_if #(parameter int WIDTH = 8);
    import led_pkg::*;
    logic [WIDTH-1:0] pattern_in;
    logic             pattern_valid;
    led_mode_e        mode_in;
    modport master (output pattern_in, pattern_valid, mode_in);
    modport slave  (input  pattern_in, pattern_valid, mode_in);
endinterface

// File: rtl/led_pattern_driver_tick_gen.sv
// led_tick_gen: prescaler and animation step counter
// clock - system clock; reset - async active-low
// clear - synchronous restart of both counters
// tick  - high on the last clock of each prescaler period
// step  - high on the tick that completes STEP_TICKS ticks
module led_tick_gen #(
    parameter int PRESCALE_DIV = 1000,
    parameter int STEP_TICKS   = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic step
);
    localparam int PW = $clog2(PRESCALE_DIV);
    localparam int SW = $clog2(STEP_TICKS + 1);
    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] step_cnt;
    assign tick = pre_cnt == PW'(PRESCALE_DIV - 1);
    assign step = tick && step_cnt == SW'(STEP_TICKS - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else if (clear) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                step_cnt <= step ? '0 : step_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: glitch-free LED pattern display with modes and PWM brightness
// clock        - system clock, rising edge
// reset        - asynchronous active-low reset
// bus          - led_pattern_driver_if.slave: pattern_in, pattern_valid, mode_in
// brightness   - live PWM duty level (all ones = always on)
// led_out      - registered LED drive
// load_pending - a captured load is waiting for the end of the PWM period
// Define LED_GAMMA_EN to pass brightness through the package gamma table.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PWM_BITS     = 4,
    parameter int PRESCALE_DIV = 1000,
    parameter int STEP_TICKS   = 250
) (
    input  logic                 clock,
    input  logic                 reset,
    led_pattern_driver_if.slave  bus,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [WIDTH-1:0]     led_out,
    output logic                 load_pending
);
    logic [PWM_BITS-1:0] pwm_cnt, level;
    logic [WIDTH-1:0]    pend_pattern, work_pattern, next_pattern, rot_l, rot_r;
    led_mode_e           pend_mode, next_mode;
    led_state_e          state;
    logic                apply, tick, step, pwm_on, lit;

`ifdef LED_GAMMA_EN
    if (PWM_BITS != 4) begin : g_bad_pwm_bits
        $error("LED_GAMMA_EN requires PWM_BITS == 4");
    end
    assign level = LED_GAMMA_LUT[brightness];
`else
    assign level = brightness;
`endif

    assign pwm_on       = (level == '1) || (pwm_cnt < level);
    // Loads only land at the end of a PWM period so a pattern never changes mid-pulse.
    assign apply        = (pwm_cnt == '1) && (load_pending || bus.pattern_valid);
    assign next_pattern = bus.pattern_valid ? bus.pattern_in : pend_pattern;
    assign next_mode    = bus.pattern_valid ? bus.mode_in : pend_mode;
    assign rot_l        = {work_pattern[WIDTH-2:0], work_pattern[WIDTH-1]};
    assign rot_r        = {work_pattern[0], work_pattern[WIDTH-1:1]};
    assign lit          = state != S_OFF && state != S_BLINK_OFF;

    led_tick_gen #(.PRESCALE_DIV(PRESCALE_DIV), .STEP_TICKS(STEP_TICKS)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (apply),
        .tick  (tick),
        .step  (step)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_cnt      <= '0;
            pend_pattern <= '0;
            pend_mode    <= MODE_STATIC;
            load_pending <= 1'b0;
            work_pattern <= '0;
            state        <= S_OFF;
            led_out      <= '0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            led_out      <= lit ? work_pattern & {WIDTH{pwm_on}} : '0;
            load_pending <= !apply && (load_pending || bus.pattern_valid);
            if (bus.pattern_valid) begin
                pend_pattern <= bus.pattern_in;
                pend_mode    <= bus.mode_in;
            end
            if (apply) begin
                work_pattern <= next_pattern;
                state        <= entry_state(next_mode);
            end else if (tick && step) begin
                case (state)
                    S_BLINK_ON:  state <= S_BLINK_OFF;
                    S_BLINK_OFF: state <= S_BLINK_ON;
                    S_ROT:       work_pattern <= rot_l;
                    S_BOUNCE_L: begin
                        state        <= work_pattern[WIDTH-1] ? S_BOUNCE_R : S_BOUNCE_L;
                        work_pattern <= work_pattern[WIDTH-1] ? rot_r : rot_l;
                    end
                    S_BOUNCE_R: begin
                        state        <= work_pattern[0] ? S_BOUNCE_L : S_BOUNCE_R;
                        work_pattern <= work_pattern[0] ? rot_l : rot_r;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver: directed self-checking bench for led_pattern_driver
module tb_led_pattern_driver;
    import led_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] brightness = 4'd15;
    logic [7:0] led_out;
    logic       load_pending;
    logic [3:0] pc;
    int         errors = 0;
    int         checks = 0;

    led_pattern_driver_if #(.WIDTH(8)) bus ();

    led_pattern_driver #(
        .WIDTH(8), .PWM_BITS(4), .PRESCALE_DIV(4), .STEP_TICKS(2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .brightness   (brightness),
        .led_out      (led_out),
        .load_pending (load_pending)
    );

    always #5 clock = ~clock;

    // Reference PWM phase: counts clocks since reset release.
    always @(posedge clock or negedge reset)
        if (!reset) pc <= 4'd0;
        else        pc <= pc + 4'd1;

    task automatic wait_pc(input int v);
        int n = 0;
        while (pc != 4'(v) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (pc != 4'(v)) begin
            checks++;
            errors++;
            $display("FAIL wait_pc: phase %0d required %0d", pc, v);
        end
    endtask

    task automatic strobe(input logic [7:0] p, input led_mode_e m);
        bus.pattern_in    = p;
        bus.mode_in       = m;
        bus.pattern_valid = 1'b1;
        @(negedge clock);
        bus.pattern_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        checks++;
        if (led_out !== 8'h00 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: led_out=%h load_pending=%b required 00/0", led_out, load_pending);
        end
        for (int i = 0; i < 100; i++) begin
            bus.pattern_in = 8'($urandom);
            bus.mode_in    = led_mode_e'($urandom_range(0, 3));
            @(negedge clock);
            checks++;
            if (led_out !== 8'h00 || load_pending !== 1'b0) begin
                errors++;
                $display("FAIL idle[%0d]: led_out=%h load_pending=%b required 00/0", i, led_out, load_pending);
            end
        end
    endtask

    task automatic test_static;
        brightness = 4'd15;
        wait_pc(3);
        strobe(8'hA5, MODE_STATIC);
        checks++;
        if (load_pending !== 1'b1) begin
            errors++;
            $display("FAIL static_pending_set: load_pending=%b required 1", load_pending);
        end
        wait_pc(15);
        checks++;
        if (load_pending !== 1'b1 || led_out !== 8'h00) begin
            errors++;
            $display("FAIL static_before_apply: load_pending=%b led_out=%h required 1/00", load_pending, led_out);
        end
        @(negedge clock);
        checks++;
        if (load_pending !== 1'b0) begin
            errors++;
            $display("FAIL static_pending_clear: load_pending=%b required 0", load_pending);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (led_out !== 8'hA5) begin
                errors++;
                $display("FAIL static_hold[%0d]: led_out=%h required a5", i, led_out);
            end
        end
    endtask

    task automatic test_pwm;
        int on_cnt, off_cnt;
        brightness = 4'd4;
        wait_pc(3);
        strobe(8'hFF, MODE_STATIC);
        wait_pc(2);
        on_cnt  = 0;
        off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (led_out === 8'hFF) on_cnt++;
            if (led_out === 8'h00) off_cnt++;
            @(negedge clock);
        end
        checks++;
        if (on_cnt != 4 || off_cnt != 12) begin
            errors++;
            $display("FAIL pwm_duty4: on=%0d off=%0d required 4/12", on_cnt, off_cnt);
        end
        brightness = 4'd0;
        repeat (2) @(negedge clock);
        off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (led_out === 8'h00) off_cnt++;
            @(negedge clock);
        end
        checks++;
        if (off_cnt != 16) begin
            errors++;
            $display("FAIL pwm_duty0: dark=%0d required 16", off_cnt);
        end
    endtask

    task automatic test_bounce;
        logic [7:0] exp_seq [11] = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                     8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        brightness = 4'd15;
        wait_pc(15);
        strobe(8'h40, MODE_BOUNCE);
        checks++;
        if (load_pending !== 1'b0) begin
            errors++;
            $display("FAIL bounce_bypass: load_pending=%b required 0", load_pending);
        end
        repeat (4) @(negedge clock);
        for (int i = 0; i < 11; i++) begin
            if (i > 0) repeat (8) @(negedge clock);
            checks++;
            if (led_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL bounce_step[%0d]: led_out=%h required %h", i, led_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_blink_override;
        logic [7:0] blink_seq [4] = '{8'h0F, 8'h00, 8'h0F, 8'h00};
        logic [7:0] rot_seq [4]   = '{8'h3C, 8'h78, 8'hF0, 8'hE1};
        wait_pc(15);
        strobe(8'h0F, MODE_BLINK);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (8) @(negedge clock);
            checks++;
            if (led_out !== blink_seq[i]) begin
                errors++;
                $display("FAIL blink[%0d]: led_out=%h required %h", i, led_out, blink_seq[i]);
            end
        end
        wait_pc(2);
        strobe(8'h55, MODE_BOUNCE);
        wait_pc(5);
        strobe(8'h3C, MODE_ROTATE);
        wait_pc(10);
        checks++;
        if (load_pending !== 1'b1) begin
            errors++;
            $display("FAIL override_pending: load_pending=%b required 1", load_pending);
        end
        wait_pc(15);
        @(negedge clock);
        checks++;
        if (load_pending !== 1'b0) begin
            errors++;
            $display("FAIL override_clear: load_pending=%b required 0", load_pending);
        end
        repeat (4) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat (8) @(negedge clock);
            checks++;
            if (led_out !== rot_seq[i]) begin
                errors++;
                $display("FAIL rotate[%0d]: led_out=%h required %h", i, led_out, rot_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        wait_pc(3);
        strobe(8'hAA, MODE_STATIC);
        checks++;
        if (load_pending !== 1'b1 || led_out === 8'h00) begin
            errors++;
            $display("FAIL mid_pre: load_pending=%b led_out=%h required 1/nonzero", load_pending, led_out);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (led_out !== 8'h00 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: led_out=%h load_pending=%b required 00/0", led_out, load_pending);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            checks++;
            if (led_out !== 8'h00 || load_pending !== 1'b0) begin
                errors++;
                $display("FAIL mid_after[%0d]: led_out=%h load_pending=%b required 00/0", i, led_out, load_pending);
            end
        end
    endtask

    initial begin
        bus.pattern_in    = 8'h00;
        bus.mode_in       = MODE_STATIC;
        bus.pattern_valid = 1'b0;
        test_reset();
        test_static();
        test_pwm();
        test_bounce();
        test_blink_override();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
